// File: rtl/cycle_termination_multi.sv
// Multi-channel CPU cycle termination generator with a bus watchdog.
// Drives the shared open-bus lines TACKn/TCIn/TBIn/TEAn low, then high, then releases them.
module cycle_termination_multi #(
  parameter int              N_CH    = 2,
  parameter int              WAIT_W  = 4,
  parameter logic [N_CH-1:0] CI_MASK = {N_CH{1'b1}},
  parameter logic [N_CH-1:0] BI_MASK = {N_CH{1'b1}},
  parameter int              TIMEOUT = 255,
  parameter int              TO_W    = 16
) (
  input  logic                     CLK40,
  input  logic                     RESETn,
  input  logic [N_CH-1:0]          TERM_REQ,
  input  logic [N_CH*WAIT_W-1:0]   WAIT_CFG,
  input  logic                     CYC_START,
  input  logic                     ERR_CLR,
  output wire                      TACKn,
  output wire                      TCIn,
  output wire                      TBIn,
  output wire                      TEAn,
  output logic                     BUSY,
  output logic                     TO_FLAG
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT       = 3'd1;
  localparam logic [2:0] ASSERT     = 3'd2;
  localparam logic [2:0] NEGATE     = 3'd3;
  localparam logic [2:0] RELEASE    = 3'd4;
  localparam logic [2:0] ERR_ASSERT = 3'd5;
  localparam logic [2:0] ERR_NEGATE = 3'd6;

  logic [2:0]        state_r, state_nxt_s;
  logic [CH_W-1:0]   ch_r, ch_nxt_s, gnt_idx_s;
  logic [WAIT_W-1:0] cnt_r, cnt_nxt_s, gnt_wait_s;
  logic [N_CH-1:0]   pending_r, req_all_s, clr_mask_s;
  logic              gnt_any_s, wd_exp_s, err_go_s;
  logic              wd_arm_r, wd_arm_nxt_s;
  logic [TO_W-1:0]   wd_cnt_r, wd_cnt_nxt_s;
  logic              en_r, tack_r, tci_r, tbi_r, tea_r, busy_r, flag_r;
  logic              en_s, tack_s, tci_s, tbi_s, tea_s;

  // Request arbitration, state transitions and watchdog next-state.
  always_comb begin
    req_all_s = pending_r | TERM_REQ;
    gnt_any_s = |req_all_s;
    gnt_idx_s = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      gnt_idx_s = req_all_s[i] ? CH_W'(i) : gnt_idx_s;
    end
    gnt_wait_s  = WAIT_CFG[gnt_idx_s*WAIT_W +: WAIT_W];
    wd_exp_s    = wd_arm_r && (wd_cnt_r == TO_W'(TIMEOUT));
    state_nxt_s = state_r;
    ch_nxt_s    = ch_r;
    cnt_nxt_s   = cnt_r;
    clr_mask_s  = '0;
    err_go_s    = 1'b0;

    case (state_r)
      // RELEASE shares the grant path so back-to-back terminations are 3 clocks apart.
      IDLE, RELEASE: begin
        if (gnt_any_s) begin
          ch_nxt_s   = gnt_idx_s;
          clr_mask_s = N_CH'(1'b1) << gnt_idx_s;
          cnt_nxt_s  = gnt_wait_s;
          if (gnt_wait_s == WAIT_W'(0)) begin
            state_nxt_s = ASSERT;
          end else begin
            state_nxt_s = WAIT;
          end
        end else if ((state_r == IDLE) && wd_exp_s) begin
          err_go_s    = 1'b1;
          state_nxt_s = ERR_ASSERT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == WAIT_W'(1)) begin
          state_nxt_s = ASSERT;
        end else begin
          cnt_nxt_s = cnt_r - WAIT_W'(1);
        end
      end
      ASSERT:     state_nxt_s = NEGATE;
      NEGATE:     state_nxt_s = RELEASE;
      ERR_ASSERT: state_nxt_s = ERR_NEGATE;
      ERR_NEGATE: state_nxt_s = RELEASE;
      default:    state_nxt_s = IDLE;
    endcase

    // An expiry outside IDLE is dropped: a termination is already under way.
    if (CYC_START) begin
      wd_arm_nxt_s = 1'b1;
      wd_cnt_nxt_s = '0;
    end else if ((state_nxt_s == ASSERT) || wd_exp_s) begin
      wd_arm_nxt_s = 1'b0;
      wd_cnt_nxt_s = wd_cnt_r;
    end else if (wd_arm_r) begin
      wd_arm_nxt_s = 1'b1;
      wd_cnt_nxt_s = wd_cnt_r + TO_W'(1);
    end else begin
      wd_arm_nxt_s = 1'b0;
      wd_cnt_nxt_s = wd_cnt_r;
    end
  end

  // Line values are decoded from the next state so they are registered on state entry.
  always_comb begin
    en_s   = 1'b0;
    tack_s = 1'b1;
    tci_s  = 1'b1;
    tbi_s  = 1'b1;
    tea_s  = 1'b1;
    case (state_nxt_s)
      ASSERT: begin
        en_s   = 1'b1;
        tack_s = 1'b0;
        tci_s  = ~CI_MASK[ch_nxt_s];
        tbi_s  = ~BI_MASK[ch_nxt_s];
      end
      NEGATE, ERR_NEGATE: en_s = 1'b1;
      ERR_ASSERT: begin
        en_s  = 1'b1;
        tea_s = 1'b0;
      end
      default: en_s = 1'b0;
    endcase
  end

  // All state, including the line drivers, updates on the falling edge.
  always_ff @(negedge CLK40) begin
    if (!RESETn) begin
      state_r   <= IDLE;
      ch_r      <= '0;
      cnt_r     <= '0;
      pending_r <= '0;
      wd_arm_r  <= 1'b0;
      wd_cnt_r  <= '0;
      en_r      <= 1'b0;
      tack_r    <= 1'b1;
      tci_r     <= 1'b1;
      tbi_r     <= 1'b1;
      tea_r     <= 1'b1;
      busy_r    <= 1'b0;
      flag_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ch_r      <= ch_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pending_r <= req_all_s & ~clr_mask_s;
      wd_arm_r  <= wd_arm_nxt_s;
      wd_cnt_r  <= wd_cnt_nxt_s;
      en_r      <= en_s;
      tack_r    <= tack_s;
      tci_r     <= tci_s;
      tbi_r     <= tbi_s;
      tea_r     <= tea_s;
      busy_r    <= (state_nxt_s != IDLE);
      flag_r    <= err_go_s ? 1'b1 : (ERR_CLR ? 1'b0 : flag_r);
    end
  end

  assign TACKn   = en_r ? tack_r : 1'bz;
  assign TCIn    = en_r ? tci_r  : 1'bz;
  assign TBIn    = en_r ? tbi_r  : 1'bz;
  assign TEAn    = en_r ? tea_r  : 1'bz;
  assign BUSY    = busy_r;
  assign TO_FLAG = flag_r;

endmodule

// File: tb/tb_cycle_termination_multi.sv
// Directed bench for cycle_termination_multi: vector table plus hand-written watchdog/reset sequences.
// Released (Z) lines read as 0 through the pulldowns on the bench nets.
module tb_cycle_termination_multi;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] term_req;
  logic [7:0] wait_cfg;
  logic       cyc_start;
  logic       err_clr;
  wire        tackn, tcin, tbin, tean;
  logic       busy, to_flag;

  pulldown (tackn);
  pulldown (tcin);
  pulldown (tbin);
  pulldown (tean);

  cycle_termination_multi #(
    .N_CH    (2),
    .WAIT_W  (4),
    .CI_MASK (2'b01),
    .BI_MASK (2'b11),
    .TIMEOUT (8),
    .TO_W    (16)
  ) dut (
    .CLK40     (clk),
    .RESETn    (rstn),
    .TERM_REQ  (term_req),
    .WAIT_CFG  (wait_cfg),
    .CYC_START (cyc_start),
    .ERR_CLR   (err_clr),
    .TACKn     (tackn),
    .TCIn      (tcin),
    .TBIn      (tbin),
    .TEAn      (tean),
    .BUSY      (busy),
    .TO_FLAG   (to_flag)
  );

  always #5 clk = ~clk;

  // exp = {TACKn, TCIn, TBIn, TEAn, BUSY, TO_FLAG} after the falling edge that consumes the inputs
  typedef struct {
    logic       rstn;
    logic [1:0] req;
    logic [7:0] wcfg;
    logic       cyc;
    logic       clr;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic [1:0] q, input logic [7:0] w,
                              input logic c, input logic e, input logic [5:0] x);
    vec_t v;
    v.rstn = r; v.req = q; v.wcfg = w; v.cyc = c; v.clr = e; v.exp = x;
    return v;
  endfunction

  task automatic step(input vec_t v, input string name);
    logic [5:0] got;
    rstn      = v.rstn;
    term_req  = v.req;
    wait_cfg  = v.wcfg;
    cyc_start = v.cyc;
    err_clr   = v.clr;
    @(negedge clk);
    @(posedge clk);
    got = {tackn, tcin, tbin, tean, busy, to_flag};
    n_vec++;
    if (got !== v.exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got {tack,tci,tbi,tea,busy,flag}=%b required %b", name, n_vec, got, v.exp);
    end
  endtask

  initial begin
    rstn = 1'b0; term_req = 2'b00; wait_cfg = 8'h30; cyc_start = 1'b0; err_clr = 1'b0;
    @(posedge clk);

    // reset, then ch0 W=0, ch1 W=3 with TCIn inhibited by CI_MASK
    vecs.push_back(mk(1'b0, 2'b00, 8'h30, 1'b0, 1'b0, 6'b000000));
    vecs.push_back(mk(1'b0, 2'b00, 8'h30, 1'b0, 1'b0, 6'b000000));
    vecs.push_back(mk(1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 6'b000000));
    vecs.push_back(mk(1'b1, 2'b01, 8'h30, 1'b0, 1'b0, 6'b000110));
    vecs.push_back(mk(1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 6'b111110));
    vecs.push_back(mk(1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 6'b000010));
    vecs.push_back(mk(1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 6'b000000));
    vecs.push_back(mk(1'b1, 2'b10, 8'h30, 1'b0, 1'b0, 6'b000010));
    vecs.push_back(mk(1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 6'b000010));
    vecs.push_back(mk(1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 6'b000010));
    vecs.push_back(mk(1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 6'b010110));
    vecs.push_back(mk(1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 6'b111110));
    vecs.push_back(mk(1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 6'b000010));
    vecs.push_back(mk(1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 6'b000000));
    // both channels on one edge: ch0 first, ch1 three clocks later, then nothing more
    vecs.push_back(mk(1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 6'b000110));
    vecs.push_back(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b111110));
    vecs.push_back(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000010));
    vecs.push_back(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b010110));
    vecs.push_back(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b111110));
    vecs.push_back(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000010));
    vecs.push_back(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000000));
    vecs.push_back(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000000));

    foreach (vecs[i]) step(vecs[i], "table");

    // watchdog expiry: armed at edge m, count hits 8 at m+8, error cycle at m+9
    step(mk(1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 6'b000000), "wd_arm");
    for (int k = 0; k < 8; k++) step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000000), "wd_count");
    step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b111011), "wd_err_assert");
    step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b111111), "wd_err_negate");
    step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000011), "wd_release");
    step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000001), "wd_flag_sticky");
    step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000001), "wd_flag_sticky");
    step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 6'b000000), "wd_err_clr");
    step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000000), "wd_after_clr");

    // termination at count 5 disarms the watchdog: no error cycle afterwards
    step(mk(1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 6'b000000), "wd5_arm");
    for (int k = 0; k < 4; k++) step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000000), "wd5_count");
    step(mk(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 6'b000110), "wd5_assert");
    step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b111110), "wd5_negate");
    step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000010), "wd5_release");
    for (int k = 0; k < 10; k++) step(mk(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 6'b000000), "wd5_quiet");

    // reset during ASSERT of a W=2 termination, with ch1 pending behind it
    step(mk(1'b1, 2'b01, 8'h02, 1'b0, 1'b0, 6'b000010), "rst_wait");
    step(mk(1'b1, 2'b10, 8'h02, 1'b0, 1'b0, 6'b000010), "rst_wait_pend");
    step(mk(1'b1, 2'b00, 8'h02, 1'b0, 1'b0, 6'b000110), "rst_assert");
    step(mk(1'b0, 2'b00, 8'h02, 1'b0, 1'b0, 6'b000000), "rst_release");
    for (int k = 0; k < 6; k++) step(mk(1'b1, 2'b00, 8'h02, 1'b0, 1'b0, 6'b000000), "rst_quiet");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
